// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_ALIGN_CHECK_EN adds the FAULT state for misaligned redirects.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int PC_INC      = 4;
  localparam int PC_READ_OFS = 8;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection: reset value,
// sequential increment from the held instruction, or word-aligned redirect.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] pc_next;

  // Only an accepted instruction advances the PC; the low two bits of a redirect are dropped.
  always_comb begin
    pc_next = pc;
    if (load) begin
      if (pc_src) begin
        pc_next = pc_target & ALIGN_MASK;
      end else begin
        pc_next = instr_pc + ADDR_W'(PC_INC);
      end
    end else begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD handshake loop.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus8,
  output logic               align_fault
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              accept;

  assign accept = (state == ST_HOLD) && instr_ready;

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .pc_src   (pc_src),
    .pc_target(pc_target),
    .instr_pc (instr_pc),
    .pc       (pc)
  );

  // Gated by reset so a request never escapes while reset is still held after the first edge.
  assign imem_req  = (state == ST_REQ) && !reset;
  assign imem_addr = pc;
  assign pc_plus8  = instr_pc + ADDR_W'(PC_READ_OFS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_REQ;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_fault <= 1'b0;
`endif
    end else begin
      case (state)
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (pc_src && (pc_target[1:0] != 2'b00)) begin
              align_fault <= 1'b1;
              state       <= ST_FAULT;
            end else begin
              state <= ST_REQ;
            end
`else
            state <= ST_REQ;
`endif
          end else begin
            state <= ST_HOLD;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_FAULT: begin
          state <= ST_FAULT;
        end
`endif
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

`ifndef FETCH_ALIGN_CHECK_EN
  assign align_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 Parameter ADDR_W, default 32, the width of the PC and instruction-memory address.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port pc_src, input, 1: redirect request from the controller's PCSrc.
REQ-006 Port pc_target, input, ADDR_W: redirect address (ALU/branch result).
REQ-007 Port imem_req, output, 1: one-cycle fetch request to instruction memory.
REQ-008 Port imem_addr, output, ADDR_W: fetch address, valid while imem_req=1.
REQ-009 Port imem_rvalid, input, 1: memory read data valid.
REQ-010 Port imem_rdata, input, 32: instruction word returned by memory.
REQ-011 Port instr_valid, output, 1: instr is valid for the controller and datapath.
REQ-012 Port instr_ready, input, 1: consumer accepts instr this cycle.
REQ-013 Port instr, output, 32: held instruction word.
REQ-014 Port instr_pc, output, ADDR_W: address of the held instruction.
REQ-015 Port pc_plus8, output, ADDR_W: instr_pc+8 (architectural PC read value).
REQ-016 Port align_fault, output, 1: sticky misaligned-redirect flag.

Function
REQ-017 The FSM SHALL have exactly three operating states: REQ, WAIT and HOLD, plus FAULT when FETCH_ALIGN_CHECK_EN is defined.
- REQ: imem_req=1, imem_addr=pc; next state is WAIT unconditionally.
- WAIT: imem_req=0; on imem_rvalid, capture imem_rdata into instr and pc into instr_pc, then go to HOLD; otherwise stay in WAIT.
- HOLD: instr_valid=1; on instr_ready ("accept"), go to REQ; otherwise hold instr and instr_pc stable.
REQ-018 The PC update on accept SHALL be:
- pc_src=1: pc <= pc_target;
- pc_src=0: pc <= instr_pc+4, with mod-2^ADDR_W wrap (32'hFFFF_FFFC+4 gives 0).
REQ-019 pc_src SHALL be sampled only on an accept cycle and ignored in every other cycle.
REQ-020 imem_rvalid SHALL be ignored outside WAIT.
REQ-021 Latency from the REQ cycle T SHALL be:
- earliest rvalid at T+1;
- earliest instr_valid at T+2;
- with back-to-back accepts and 1-cycle memory, one instruction every 3 cycles.
REQ-022 instr_valid SHALL be 0 in REQ and WAIT, and instr SHALL NOT change while instr_valid=1.
REQ-023 pc_plus8 SHALL be combinational from instr_pc (instr_pc+8, wrapping).

Reset
REQ-024 When reset=1 at a clock edge, the following SHALL hold on the next cycle, regardless of state or outstanding request:
- state=REQ, pc=RESET_PC;
- instr=0, instr_pc=0;
- instr_valid=0, align_fault=0.
REQ-025 While reset=1, imem_req SHALL be 0.
REQ-026 A memory response arriving in the cycle after reset (i.e. in REQ) SHALL be discarded per REQ-020.

Configuration
REQ-027 With FETCH_ALIGN_CHECK_EN defined, an accept with pc_src=1 and pc_target[1:0]!=0 SHALL:
- set align_fault=1;
- move to FAULT: no requests, instr_valid=0, exit only by reset.
REQ-028 Without FETCH_ALIGN_CHECK_EN, the redirect SHALL load {pc_target[ADDR_W-1:2],2'b00}, align_fault SHALL be tied 0, and FAULT SHALL NOT exist.

Structure
REQ-029 Package fetch_pkg SHALL hold:
- the FSM state enum typedef;
- the constants INSTR_W=32, PC_INC=4, PC_READ_OFS=8.
REQ-030 Sub-module fetch_pc_reg SHALL hold the pc register and its next-PC mux (reset, increment, redirect, alignment masking).

Verification
REQ-031 Reset test: reset high 2 cycles, RESET_PC=32'h100, 1-cycle memory -> imem_req with imem_addr=32'h100 in the first cycle after reset; instr_valid rises two cycles later.
REQ-032 Backpressure test: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no imem_req; after accept, next imem_addr=instr_pc+4.
REQ-033 Redirect test: accept with pc_src=1, pc_target=32'h40 -> next imem_addr=32'h40 and pc_plus8=32'h48 on the fetched instruction; pc_src=1 in WAIT alone -> no effect.
REQ-034 Latency and wrap test: 3-cycle memory latency -> instr_valid exactly 4 cycles after the REQ cycle; sequential fetch from 32'hFFFF_FFFC -> next imem_addr=0.
REQ-035 Alignment test: redirect to 32'h42 -> with macro, align_fault=1 and imem_req stays 0 until reset; without macro, next imem_addr=32'h40 and align_fault=0.
REQ-036 Stray-response test: imem_rvalid asserted in REQ or HOLD -> instr unchanged.
